// File: rtl/cbus_clint.sv
// cbus_clint: core-local interruptor on CBus.
// Holds msip, mtimecmp and a free-running mtime. Drives trint/swint to the core.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   creq   arbitrated CBus request (valid,is_write,size,addr,strobe,data,len)
//   cresp  CBus response (ready,last,data)
//   trint  registered timer interrupt: mtime >= mtimecmp (unsigned)
//   swint  registered software interrupt: msip[0]
// len encodes beats-1, so a single-beat access carries len=0.
package cbus_clint_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_clint
  import cbus_clint_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       trint,
  output logic       swint
);
  localparam int unsigned  PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
  localparam int unsigned  NUM_LANES = 8;

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state, state_nx;
  logic [15:0] off_q;
  logic        wr_q;
  logic [7:0]  len_q, beat;

  logic [PW-1:0] presc;
  logic          tick;
  logic [63:0]   mtime, mtimecmp, mtime_inc, mtime_nx, mtimecmp_nx, rdata;
  logic          msip, msip_nx;
  logic          wr_en, wr_msip, wr_cmp, wr_time;
  logic [63:0]   wmask;

  // Decode only looks at addr[15:0]; BASE and the remaining request bits are
  // carried here so the intent is explicit.
  logic unused_ok;
  assign unused_ok = ^{BASE, creq.size, creq.addr[63:16], creq.addr[2:0]};

  // Per-byte write mask from strobe.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_mask
    assign wmask[i*8 +: 8] = {8{creq.strobe[i]}};
  end

  always_comb begin
    rdata = '0;
    case (off_q)
      OFF_MSIP:     rdata = {63'b0, msip};
      OFF_MTIMECMP: rdata = mtimecmp;
      OFF_MTIME:    rdata = mtime;
      default:      rdata = '0;
    endcase
  end

  // FSM next-state and response.
  always_comb begin
    state_nx = state;
    cresp    = '0;
    wr_en    = 1'b0;
    case (state)
      IDLE: if (creq.valid) state_nx = RESP;
      RESP: begin
        cresp.ready = 1'b1;
        cresp.last  = (beat == len_q);
        cresp.data  = rdata;
        wr_en       = wr_q;
        if (cresp.last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset silences the bus and suppresses the in-flight beat's write.
    if (reset) begin
      state_nx = IDLE;
      cresp    = '0;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      off_q <= '0;
      wr_q  <= 1'b0;
      len_q <= '0;
      beat  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && creq.valid) begin
        off_q <= {creq.addr[15:3], 3'b000};
        wr_q  <= creq.is_write;
        len_q <= creq.len;
        beat  <= '0;
      end else if (state == RESP) begin
        beat <= beat + 8'd1;
      end
    end
  end

  // Timer and register updates.
  assign tick      = (presc == PS_MAX);
  assign mtime_inc = mtime + 64'(tick);
  assign wr_msip   = wr_en && (off_q == OFF_MSIP);
  assign wr_cmp    = wr_en && (off_q == OFF_MTIMECMP);
  assign wr_time   = wr_en && (off_q == OFF_MTIME);

  // A write to mtime on a tick cycle wins; unstrobed bytes still take the tick.
  assign mtime_nx    = wr_time ? ((creq.data & wmask) | (mtime_inc & ~wmask)) : mtime_inc;
  assign mtimecmp_nx = wr_cmp  ? ((creq.data & wmask) | (mtimecmp  & ~wmask)) : mtimecmp;
  assign msip_nx     = (wr_msip && creq.strobe[0]) ? creq.data[0] : msip;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      trint    <= 1'b0;
      swint    <= 1'b0;
    end else begin
      presc    <= tick ? '0 : presc + PW'(1);
      mtime    <= mtime_nx;
      mtimecmp <= mtimecmp_nx;
      msip     <= msip_nx;
      // Interrupts follow the post-update values, one cycle after commit.
      trint    <= (mtime_nx >= mtimecmp_nx);
      swint    <= msip_nx;
    end
  end
endmodule
